// File: rtl/id_hazard_ctrl.sv
// ID->EX pipeline sequencer: load-use stall, multi-cycle EX wait and redirect flush control.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module id_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned REG_AW       = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic              ex_valid_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_busy_i,
    input  logic              ex_redirect_i,
    output logic              pc_hold_o,
    output logic              id_hold_o,
    output logic              ex_bubble_o,
    output logic              id_kill_o,
    output logic              if_kill_o,
    output logic [1:0]        ctrl_state_o,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       bubble_cycles_o
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLdStall = 2'd1,
        StFlush   = 2'd2,
        StExWait  = 2'd3
    } state_e;

    localparam logic [3:0] FlushLoad = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       haz;

    assign haz = id_valid_i & ex_valid_i & ex_is_load_i & (ex_rd_i != '0) &
                 ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                  (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_hold_o   = 1'b0;
        id_hold_o   = 1'b0;
        ex_bubble_o = 1'b0;
        id_kill_o   = 1'b0;
        if_kill_o   = 1'b0;
        if (reset_i) begin
            state_d = StRun;
            cnt_d   = 4'd0;
        end else if (ex_redirect_i) begin
            if_kill_o   = 1'b1;
            id_kill_o   = 1'b1;
            ex_bubble_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = StFlush;
                cnt_d   = FlushLoad;
            end else begin
                state_d = StRun;
            end
        end else begin
            unique case (state_q)
                // EXWAIT with busy dropped behaves exactly like RUN
                StRun, StExWait: begin
                    if (ex_busy_i) begin
                        pc_hold_o = 1'b1;
                        id_hold_o = 1'b1;
                        state_d   = StExWait;
                    end else if (haz) begin
                        pc_hold_o   = 1'b1;
                        id_hold_o   = 1'b1;
                        ex_bubble_o = 1'b1;
                        state_d     = StLdStall;
                    end else begin
                        state_d = StRun;
                    end
                end
                // haz is not re-evaluated here, so a load costs at most one bubble
                StLdStall: begin
                    if (ex_busy_i) begin
                        pc_hold_o = 1'b1;
                        id_hold_o = 1'b1;
                        state_d   = StExWait;
                    end else begin
                        state_d = StRun;
                    end
                end
                StFlush: begin
                    ex_bubble_o = 1'b1;
                    id_kill_o   = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    assign ctrl_state_o = reset_i ? 2'd0 : state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, bubble_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q  <= 32'd0;
            bubble_q <= 32'd0;
        end else begin
            if (pc_hold_o)   stall_q  <= stall_q + 32'd1;
            if (ex_bubble_o) bubble_q <= bubble_q + 32'd1;
        end
    end

    assign stall_cycles_o  = stall_q;
    assign bubble_cycles_o = bubble_q;
`else
    assign stall_cycles_o  = 32'd0;
    assign bubble_cycles_o = 32'd0;
`endif

endmodule
